// File: rtl/t21_port_arbiter.sv
// -----------------------------------------------------------------------------
// t21_port_arbiter
//
// Source-port scheduler for one read operand of a t21 node. The four
// directional input streams (left/right/up/down) are shared among direct,
// ANY, LAST and NIL read requests. Each accepted request yields exactly one
// word on the registered output stream. The port that served the most recent
// ANY read is remembered as the LAST port (TIS-100 semantics).
//
// Build option:
//   T21_ARB_ROUND_ROBIN_EN  defined   -> ANY priority rotates. The search
//                                        starts at the port after last_port
//                                        (at L when no LAST is recorded) and
//                                        wraps D -> L.
//                           undefined -> fixed ANY order L, R, U, D.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   <dir>_in_data/valid/ready  four neighbour streams; ready is a one-cycle
//                              consume strobe (dir = left, right, up, down)
//   req, req_ready, sel        request handshake and source select
//                              (0 L, 1 R, 2 U, 3 D, 4 ANY, 5 LAST, 6/7 NIL)
//   out_data, out_valid        registered result word, held until out_ready
//   out_ready                  execute stage accepts out_data
//   last_port, last_set        recorded LAST port and its validity flag
// -----------------------------------------------------------------------------
module t21_port_arbiter #(
    parameter int                DATA_W    = 11,
    parameter logic [DATA_W-1:0] NIL_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [DATA_W-1:0] left_in_data,
    input  logic              left_in_valid,
    output logic              left_in_ready,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic              right_in_valid,
    output logic              right_in_ready,
    input  logic [DATA_W-1:0] up_in_data,
    input  logic              up_in_valid,
    output logic              up_in_ready,
    input  logic [DATA_W-1:0] down_in_data,
    input  logic              down_in_valid,
    output logic              down_in_ready,

    input  logic              req,
    output logic              req_ready,
    input  logic [2:0]        sel,

    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,

    output logic [1:0]        last_port,
    output logic              last_set
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] SEL_ANY  = 3'd4;
    localparam logic [2:0] SEL_LAST = 3'd5;

    state_t            state_q;
    logic [2:0]        sel_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic [1:0]        last_port_q;
    logic              last_set_q;

    // Port-indexed views of the four streams (0 L, 1 R, 2 U, 3 D).
    logic [3:0]        in_valid;
    logic [DATA_W-1:0] in_data [4];
    logic [3:0]        in_ready;

    assign in_valid   = {down_in_valid, up_in_valid, right_in_valid, left_in_valid};
    assign in_data[0] = left_in_data;
    assign in_data[1] = right_in_data;
    assign in_data[2] = up_in_data;
    assign in_data[3] = down_in_data;

    assign left_in_ready  = in_ready[0];
    assign right_in_ready = in_ready[1];
    assign up_in_ready    = in_ready[2];
    assign down_in_ready  = in_ready[3];

    // ------------------------------------------------------------------
    // ANY search: rot_idx[k] is the k-th port to consider, rot_valid[k]
    // its valid. The first valid entry in rotated order wins.
    // ------------------------------------------------------------------
    logic [1:0] any_start;
    logic [1:0] rot_idx   [4];
    logic [3:0] rot_valid;
    logic       any_hit;
    logic [1:0] any_port;

`ifdef T21_ARB_ROUND_ROBIN_EN
    // 2-bit addition wraps D -> L naturally.
    assign any_start = last_set_q ? (last_port_q + 2'd1) : 2'd0;
`else
    assign any_start = 2'd0;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi]   = any_start + 2'(gi);
            assign rot_valid[gi] = in_valid[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        any_hit  = 1'b0;
        any_port = 2'd0;
        // Walk from lowest priority up so the highest-priority hit is the
        // one left standing.
        for (int i = 3; i >= 0; i--) begin
            if (rot_valid[i]) begin
                any_hit  = 1'b1;
                any_port = rot_idx[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant for the pending request. Only meaningful in WAIT, where sel_q
    // is 0..5; LAST only reaches WAIT with a recorded port.
    // ------------------------------------------------------------------
    logic [1:0] grant_port;
    logic       grant_ok;
    logic       take;

    always_comb begin
        grant_port = sel_q[1:0];
        grant_ok   = in_valid[sel_q[1:0]];
        case (sel_q)
            SEL_ANY: begin
                grant_port = any_port;
                grant_ok   = any_hit;
            end
            SEL_LAST: begin
                grant_port = last_port_q;
                grant_ok   = in_valid[last_port_q];
            end
            default: begin
                grant_port = sel_q[1:0];
                grant_ok   = in_valid[sel_q[1:0]];
            end
        endcase
    end

    // The transfer happens in the cycle ready is shown. Gating with reset
    // keeps a word from being consumed in a cycle whose result is discarded.
    assign take = (state_q == WAIT) && grant_ok && !reset;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign in_ready[gi] = take && (grant_port == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            last_port_q <= 2'd0;
            last_set_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        sel_q <= sel;
                        if ((sel <= SEL_ANY) || ((sel == SEL_LAST) && last_set_q)) begin
                            state_q <= WAIT;
                        end else begin
                            // NIL, or LAST with nothing recorded: no port
                            // is touched and the answer is immediate.
                            out_data_q  <= NIL_VALUE;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                WAIT: begin
                    if (take) begin
                        out_data_q  <= in_data[grant_port];
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                        if (sel_q == SEL_ANY) begin
                            last_port_q <= grant_port;
                            last_set_q  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign last_port = last_port_q;
    assign last_set  = last_set_q;

endmodule

// File: tb/tb_t21_port_arbiter.sv
module tb_t21_port_arbiter;

`ifdef T21_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        in_v;
    logic [3:0][10:0]  in_d;
    logic              l_rdy, r_rdy, u_rdy, d_rdy;
    logic              req, req_ready, out_valid, out_ready, last_set;
    logic [2:0]        sel;
    logic [10:0]       out_data;
    logic [1:0]        last_port;
    logic [3:0]        rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rdy = {d_rdy, u_rdy, r_rdy, l_rdy};

    t21_port_arbiter #(.DATA_W(11), .NIL_VALUE(11'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .left_in_data   (in_d[0]),
        .left_in_valid  (in_v[0]),
        .left_in_ready  (l_rdy),
        .right_in_data  (in_d[1]),
        .right_in_valid (in_v[1]),
        .right_in_ready (r_rdy),
        .up_in_data     (in_d[2]),
        .up_in_valid    (in_v[2]),
        .up_in_ready    (u_rdy),
        .down_in_data   (in_d[3]),
        .down_in_valid  (in_v[3]),
        .down_in_ready  (d_rdy),
        .req            (req),
        .req_ready      (req_ready),
        .sel            (sel),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .last_port      (last_port),
        .last_set       (last_set)
    );

    typedef struct {
        logic [2:0]       sel;
        logic [3:0]       vld;
        logic [3:0][10:0] d;
        logic [10:0]      exp_d;
        int               exp_port;   // 4 = no port consumed
        int               exp_lat;
        logic [1:0]       exp_lp;
        logic             exp_ls;
    } vec_t;

    vec_t tv [10];

    function automatic logic [3:0][10:0] mk(input int lf, input int rt, input int up, input int dn);
        return {11'(dn), 11'(up), 11'(rt), 11'(lf)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called and returns at a falling edge. Issues one request, waits for
    // out_valid, checks result/latency/ready pulses/LAST tracking, holds the
    // word for 'hold' extra cycles, then retires it.
    task automatic xact(input string name, input logic [2:0] s, input logic [3:0] v,
                        input logic [3:0][10:0] d, input logic [10:0] exp_d,
                        input int exp_port, input int exp_lat,
                        input logic [1:0] exp_lp, input logic exp_ls, input int hold);
        int lat;
        int rdy_cnt;
        logic [3:0] rdy_or;
        logic [3:0] exp_mask;
        chk({name, ".req_ready"}, req_ready, 1);
        in_v = v; in_d = d; sel = s; req = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        lat = 1; rdy_cnt = 0; rdy_or = 4'd0;
        for (int c = 0; c < 50; c++) begin
            rdy_cnt += $countones(rdy);
            rdy_or  |= rdy;
            if (out_valid) break;
            @(negedge clk);
            lat++;
        end
        in_v = 4'd0;
        exp_mask = (exp_port == 4) ? 4'd0 : 4'(1 << exp_port);
        chk({name, ".out_valid"}, out_valid, 1);
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".out_data"}, out_data, exp_d);
        chk({name, ".ready_pulses"}, rdy_cnt, (exp_port == 4) ? 0 : 1);
        chk({name, ".ready_port"}, rdy_or, exp_mask);
        chk({name, ".last_set"}, last_set, exp_ls);
        chk({name, ".last_port"}, last_port, exp_lp);
        $display("xact %s sel=%0d out_data=%0d lat=%0d ready=%b last=%0d/%0d",
                 name, s, $signed(out_data), lat, rdy_or, last_set, last_port);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, ".hold_valid"}, out_valid, 1);
            chk({name, ".hold_data"}, out_data, exp_d);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".retire_valid"}, out_valid, 0);
        chk({name, ".retire_req_ready"}, req_ready, 1);
    endtask

    initial begin
        int m_lp;
        int m_ls;
        int bad;
        int p;
        int start;
        logic [3:0] cand;
        logic [3:0] v;
        logic [2:0] s;
        logic [3:0][10:0] d;

        //          sel   vld       data L,R,U,D              exp_d                  port             lat lp                   ls
        tv[0] = '{3'd2, 4'b0100, mk(0, 0, 5, 0),           11'd5,                 2,               2, 2'd0,                1'b0};
        tv[1] = '{3'd4, 4'b1010, mk(0, 7, 0, -3),          11'd7,                 1,               2, 2'd1,                1'b1};
        tv[2] = '{3'd4, 4'b1010, mk(0, 8, 0, -3),          RR ? 11'h7FD : 11'd8,  RR ? 3 : 1,      2, RR ? 2'd3 : 2'd1,    1'b1};
        tv[3] = '{3'd5, 4'b1111, mk(22, 11, 44, 33),       RR ? 11'd33 : 11'd11,  RR ? 3 : 1,      2, RR ? 2'd3 : 2'd1,    1'b1};
        tv[4] = '{3'd6, 4'b1111, mk(1, 2, 3, 4),           11'd0,                 4,               1, RR ? 2'd3 : 2'd1,    1'b1};
        tv[5] = '{3'd7, 4'b1111, mk(1, 2, 3, 4),           11'd0,                 4,               1, RR ? 2'd3 : 2'd1,    1'b1};
        tv[6] = '{3'd0, 4'b0001, mk(-1024, 5, 6, 7),       11'h400,               0,               2, RR ? 2'd3 : 2'd1,    1'b1};
        tv[7] = '{3'd3, 4'b1111, mk(1, 2, 3, 1023),        11'd1023,              3,               2, RR ? 2'd3 : 2'd1,    1'b1};
        tv[8] = '{3'd4, 4'b0100, mk(1, 2, 77, 4),          11'd77,                2,               2, 2'd2,                1'b1};
        tv[9] = '{3'd4, 4'b1111, mk(1, 2, 3, 4),           RR ? 11'd4 : 11'd1,    RR ? 3 : 0,      2, RR ? 2'd3 : 2'd0,    1'b1};

        reset = 1'b1; req = 1'b0; sel = 3'd0; out_ready = 1'b0;
        in_v = 4'd0; in_d = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.req_ready", req_ready, 1);
        chk("reset.ready", rdy, 0);
        chk("reset.last_set", last_set, 0);
        chk("reset.last_port", last_port, 0);
        chk("reset.out_data", out_data, 0);

        for (int i = 0; i < 10; i++) begin
            xact($sformatf("tv%0d", i), tv[i].sel, tv[i].vld, tv[i].d, tv[i].exp_d,
                 tv[i].exp_port, tv[i].exp_lat, tv[i].exp_lp, tv[i].exp_ls, i % 3);
        end

        // Direct read blocked on an idle port, then reset mid-wait.
        in_v = 4'd0; sel = 3'd0; req = 1'b1;
        @(negedge clk);
        req = 1'b0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (rdy != 4'd0 || out_valid || req_ready) bad = 1;
            @(negedge clk);
        end
        chk("wait_blocked", bad, 0);
        in_v = 4'b0001; in_d = mk(999, 0, 0, 0); reset = 1'b1;
        #1;
        chk("reset_cycle.no_ready", rdy, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("midwait_reset.req_ready", req_ready, 1);
        chk("midwait_reset.out_valid", out_valid, 0);
        chk("midwait_reset.last_set", last_set, 0);
        chk("midwait_reset.no_ready", rdy, 0);
        $display("xact midwait_reset req_ready=%0d out_valid=%0d", req_ready, out_valid);
        xact("left999_hold", 3'd0, 4'b0001, mk(999, 0, 0, 0), 11'd999, 0, 2, 2'd0, 1'b0, 6);
        xact("last_no_record", 3'd5, 4'b1111, mk(1, 2, 3, 4), 11'd0, 4, 1, 2'd0, 1'b0, 0);

        // Randomized requests against a rule-level model of the scheduler.
        m_lp = 0; m_ls = 0;
        for (int n = 0; n < 60; n++) begin
            s = 3'($urandom_range(0, 7));
            v = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) d[k] = 11'($urandom);
            if (s < 3'd4)        cand = 4'(1 << s);
            else if (s == 3'd4)  cand = 4'b1111;
            else if (s == 3'd5)  cand = (m_ls != 0) ? 4'(1 << m_lp) : 4'd0;
            else                 cand = 4'd0;
            if (cand != 4'd0 && (v & cand) == 4'd0) begin
                if (s == 3'd4) v[$urandom_range(0, 3)] = 1'b1;
                else           v = v | cand;
            end
            if (cand == 4'd0) begin
                xact($sformatf("rnd%0d", n), s, v, d, 11'd0, 4, 1, 2'(m_lp), m_ls[0], $urandom_range(0, 2));
            end else begin
                if (s == 3'd4) begin
                    start = (RR && m_ls != 0) ? (m_lp + 1) % 4 : 0;
                    p = -1;
                    for (int k = 0; k < 4; k++)
                        if (p < 0 && v[(start + k) % 4]) p = (start + k) % 4;
                    m_lp = p; m_ls = 1;
                end else if (s == 3'd5) begin
                    p = m_lp;
                end else begin
                    p = int'(s);
                end
                xact($sformatf("rnd%0d", n), s, v, d, d[p], p, 2, 2'(m_lp), m_ls[0], $urandom_range(0, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
